// File: rtl/ad9911_pkg.sv
// Shared definitions for the AD9911 configuration sequencer: register map,
// FSM states, the latched request record and register data formatting.
package ad9911_pkg;

    localparam logic [7:0] ADDR_CSR   = 8'h00;
    localparam logic [7:0] ADDR_CTW0  = 8'h04;
    localparam logic [7:0] ADDR_CPOW0 = 8'h05;
    localparam logic [7:0] ADDR_ACR   = 8'h06;

    localparam int ACR_MULT_EN_BIT = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_REQ,
        ST_WAIT,
        ST_FIN,
        ST_ABORT
    } state_t;

    typedef struct packed {
        logic [3:0]  wr_en;
        logic [31:0] ftw;
        logic [13:0] pow;
        logic [9:0]  asf;
    } cfg_req_t;

    // Write slot index 0..3 maps to CSR, CTW0, CPOW0, ACR in issue order.
    function automatic logic [7:0] reg_addr_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return ADDR_CSR;
            2'd1:    return ADDR_CTW0;
            2'd2:    return ADDR_CPOW0;
            default: return ADDR_ACR;
        endcase
    endfunction

    function automatic logic [31:0] reg_data_of(input logic [1:0] idx,
                                                input logic [3:0] ch_en,
                                                input cfg_req_t   req);
        logic [31:0] d;
        d = '0;
        case (idx)
            2'd0:    d = {24'b0, ch_en, 4'b0000};
            2'd1:    d = req.ftw;
            2'd2:    d = {18'b0, req.pow};
            default: begin
                d = {22'b0, req.asf};
                d[ACR_MULT_EN_BIT] = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ad9911_hs_timer.sv
// Saturating handshake-phase timer; expired stays high once the limit is
// reached until the next clear.
module ad9911_hs_timer #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic clr,
    input  logic tick,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (tick && cnt != LIMIT)
            cnt <= cnt + W'(1);
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/ad9911_cfg_seq.sv
// Issues the enabled AD9911 channel register writes one at a time over the
// serial writer's TR/OVER handshake, then pulses DONE or ERR.
module ad9911_cfg_seq
    import ad9911_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 1023,
    parameter logic [3:0] CSR_CH_EN   = 4'b0001
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [3:0]  WR_EN,
    input  logic [31:0] FTW,
    input  logic [13:0] POW,
    input  logic [9:0]  ASF,
    input  logic        OVER,
    output logic        TR,
    output logic [7:0]  REG_ADDR,
    output logic [31:0] DATA_IN,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    state_t   state, state_nxt;
    cfg_req_t req;
    logic [2:0] ptr;
    logic       sel_found;
    logic [1:0] sel_idx;
    logic       tmr_clr, tmr_tick, tmr_expired;

    // Lowest enabled slot at or above the pointer.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!sel_found && req.wr_en[i] && 3'(i) >= ptr) begin
                sel_found = 1'b1;
                sel_idx   = 2'(i);
            end
        end
    end

    assign tmr_clr  = (state == ST_SEL) || (state == ST_REQ && !OVER);
    assign tmr_tick = (state == ST_REQ) || (state == ST_WAIT);

    ad9911_hs_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .clr     (tmr_clr),
        .tick    (tmr_tick),
        .expired (tmr_expired)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // A handshake that progresses on the same cycle the timer expires wins.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (START) state_nxt = ST_SEL;
            ST_SEL:   state_nxt = sel_found ? ST_REQ : ST_FIN;
            ST_REQ: begin
                if (!OVER)            state_nxt = ST_WAIT;
                else if (tmr_expired) state_nxt = ST_ABORT;
            end
            ST_WAIT: begin
                if (OVER)             state_nxt = ST_SEL;
                else if (tmr_expired) state_nxt = ST_ABORT;
            end
            ST_FIN:   state_nxt = ST_IDLE;
            ST_ABORT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        TR   = (state == ST_REQ);
        BUSY = (state != ST_IDLE);
        DONE = (state == ST_FIN);
        ERR  = (state == ST_ABORT);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            req      <= '0;
            ptr      <= '0;
            REG_ADDR <= '0;
            DATA_IN  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (START) begin
                    req <= '{wr_en: WR_EN, ftw: FTW, pow: POW, asf: ASF};
                    ptr <= '0;
                end
                ST_SEL: if (sel_found) begin
                    ptr      <= {1'b0, sel_idx};
                    REG_ADDR <= reg_addr_of(sel_idx);
                    DATA_IN  <= reg_data_of(sel_idx, CSR_CH_EN, req);
                end
                ST_WAIT: if (OVER) ptr <= ptr + 3'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ad9911_cfg_seq.sv
// Scoreboard bench: stimulus pushes expected transfers/completions, a monitor
// pops and compares on every TR rise, DONE or ERR.
module tb_ad9911_cfg_seq;

    localparam int K_XFER = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start_t;
    logic [3:0]  wr_en;
    logic [31:0] ftw;
    logic [13:0] pow;
    logic [9:0]  asf;
    logic        over_a, over_t;

    logic        tr_a, busy_a, done_a, err_a;
    logic [7:0]  addr_a;
    logic [31:0] data_a;
    logic        tr_t, busy_t, done_t, err_t;
    logic [7:0]  addr_t;
    logic [31:0] data_t;

    always #5 clk = ~clk;

    ad9911_cfg_seq #(.TIMEOUT_CYC(1023), .CSR_CH_EN(4'b0001)) dut (
        .CLK(clk), .RESET_N(rst_n), .START(start), .WR_EN(wr_en),
        .FTW(ftw), .POW(pow), .ASF(asf), .OVER(over_a),
        .TR(tr_a), .REG_ADDR(addr_a), .DATA_IN(data_a),
        .BUSY(busy_a), .DONE(done_a), .ERR(err_a)
    );

    ad9911_cfg_seq #(.TIMEOUT_CYC(15), .CSR_CH_EN(4'b0001)) dut_t (
        .CLK(clk), .RESET_N(rst_n), .START(start_t), .WR_EN(wr_en),
        .FTW(ftw), .POW(pow), .ASF(asf), .OVER(over_t),
        .TR(tr_t), .REG_ADDR(addr_t), .DATA_IN(data_t),
        .BUSY(busy_t), .DONE(done_t), .ERR(err_t)
    );

    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   tr_rises = 0;
    logic tr_prev = 1'b0;
    int   w_lat  = 1;
    int   w_hold = 2;

    task automatic check(input string name, input bit ok,
                         input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_x(input logic [7:0] a, input logic [31:0] d);
        exp_q.push_back('{kind: K_XFER, addr: a, data: d});
    endtask

    task automatic push_evt(input int k);
        exp_q.push_back('{kind: k, addr: 8'h00, data: 32'h0});
    endtask

    task automatic mon_event(input int k, input logic [7:0] a, input logic [31:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", 1'b0, {24'(k), a, d}, 64'h0);
        end else begin
            e = exp_q.pop_front();
            check("scoreboard_event", k == e.kind && a == e.addr && d == e.data,
                  {24'(k), a, d}, {24'(e.kind), e.addr, e.data});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (tr_a && !tr_prev) begin
                tr_rises++;
                mon_event(K_XFER, addr_a, data_a);
            end
            if (done_a) mon_event(K_DONE, 8'h00, 32'h0);
            if (err_a)  mon_event(K_ERR, 8'h00, 32'h0);
        end
        tr_prev <= tr_a;
    end

    // Writer model: acknowledges each request after w_lat cycles, busy for w_hold.
    initial begin
        forever begin
            @(negedge clk);
            if (tr_a) begin
                repeat (w_lat) @(negedge clk);
                over_a = 1'b0;
                repeat (w_hold) @(negedge clk);
                over_a = 1'b1;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!busy_a) break;
            @(negedge clk);
        end
        check("idle_within_budget", !busy_a, 64'(busy_a), 64'h0);
    endtask

    task automatic wait_tr_addr(input logic [7:0] a, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (tr_a && addr_a == a) seen = 1'b1;
        end
        check("tr_seen_within_budget", seen, 64'(addr_a), 64'(a));
    endtask

    initial begin
        int trc;
        int rises0;
        rst_n = 1'b0; start = 1'b0; start_t = 1'b0;
        wr_en = 4'h0; ftw = '0; pow = '0; asf = '0;
        over_a = 1'b1; over_t = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {tr_a, busy_a, done_a, err_a} == 4'b0,
              64'({tr_a, busy_a, done_a, err_a}), 64'h0);
        check("reset_addr_data", addr_a == 8'h0 && data_a == 32'h0,
              {24'h0, addr_a, data_a}, 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All four registers.
        wr_en = 4'b1111; ftw = 32'h1999_999A; pow = 14'h0800; asf = 10'h3FF;
        push_x(8'h00, 32'h0000_0010); push_x(8'h04, 32'h1999_999A);
        push_x(8'h05, 32'h0000_0800); push_x(8'h06, 32'h0000_13FF);
        push_evt(K_DONE);
        pulse_start();
        wait_idle(200);

        // Single CTW0 write.
        wr_en = 4'b0010; ftw = 32'hDEAD_BEEF;
        push_x(8'h04, 32'hDEAD_BEEF); push_evt(K_DONE);
        pulse_start();
        wait_idle(200);

        // Nothing enabled: DONE two cycles after START, no TR.
        wr_en = 4'b0000;
        rises0 = tr_rises;
        push_evt(K_DONE);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("empty_busy_n1", busy_a && !done_a, {62'h0, busy_a, done_a}, 64'h2);
        @(negedge clk);
        check("empty_done_n2", busy_a && done_a, {62'h0, busy_a, done_a}, 64'h3);
        @(negedge clk);
        check("empty_idle_n3", !busy_a && !done_a, {62'h0, busy_a, done_a}, 64'h0);
        check("empty_no_tr", tr_rises == rises0, 64'(tr_rises), 64'(rises0));

        // Timeout with OVER stuck high on the short-timeout instance.
        wr_en = 4'b1111;
        @(negedge clk); start_t = 1'b1;
        @(negedge clk); start_t = 1'b0;
        trc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tr_t) begin
                if (trc == 0)
                    check("tmo_first_xfer", addr_t == 8'h00 && data_t == 32'h10,
                          {24'h0, addr_t, data_t}, 64'h0000_0000_0000_0010);
                trc++;
            end
            if (err_t) break;
        end
        check("tmo_tr_cycles", trc == 16, 64'(trc), 64'd16);
        check("tmo_err_cycle", err_t && busy_t && !tr_t,
              {61'h0, err_t, busy_t, tr_t}, 64'h6);
        @(negedge clk);
        check("tmo_after", !err_t && !busy_t && !tr_t,
              {61'h0, err_t, busy_t, tr_t}, 64'h0);

        // START and data changes mid-sequence are ignored.
        wr_en = 4'b1111; ftw = 32'h1234_5678; pow = 14'h1ABC; asf = 10'h155;
        push_x(8'h00, 32'h0000_0010); push_x(8'h04, 32'h1234_5678);
        push_x(8'h05, 32'h0000_1ABC); push_x(8'h06, 32'h0000_1155);
        push_evt(K_DONE);
        pulse_start();
        wait_tr_addr(8'h00, 50);
        @(negedge clk);
        start = 1'b1; ftw = 32'hFFFF_FFFF; pow = 14'h0; asf = 10'h0; wr_en = 4'b0000;
        @(negedge clk);
        start = 1'b0;
        wait_idle(200);

        // Long writer hold stays well under the 1023-cycle timeout.
        w_hold = 300;
        wr_en = 4'b0101; pow = 14'h3FFF;
        push_x(8'h00, 32'h0000_0010); push_x(8'h05, 32'h0000_3FFF);
        push_evt(K_DONE);
        pulse_start();
        wait_idle(2000);

        // Async reset while waiting on CTW0, then restart from CSR.
        w_hold = 20;
        wr_en = 4'b1111; ftw = 32'h0BAD_F00D;
        push_x(8'h00, 32'h0000_0010); push_x(8'h04, 32'h0BAD_F00D);
        pulse_start();
        wait_tr_addr(8'h04, 100);
        repeat (3) @(negedge clk);
        check("pre_reset_wait", busy_a && !tr_a, {62'h0, busy_a, tr_a}, 64'h2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ctrl", !tr_a && !busy_a, {62'h0, tr_a, busy_a}, 64'h0);
        check("async_rst_addr_data", addr_a == 8'h0 && data_a == 32'h0,
              {24'h0, addr_a, data_a}, 64'h0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        w_hold = 2;
        wr_en = 4'b0001;
        push_x(8'h00, 32'h0000_0010); push_evt(K_DONE);
        pulse_start();
        wait_idle(200);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size() == 0, 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ad9911_cfg_seq.md
# ad9911_cfg_seq

Upstream command sequencer for the AD9911 serial register writer. Takes one channel-configuration request (frequency tuning word, phase offset, amplitude scale) and issues the required register writes one at a time over the writer's TR / REG_ADDR / DATA_IN / OVER handshake. Each write runs to completion before the next is issued. The block then reports completion or a handshake timeout.

## Interface
- TIMEOUT_CYC, 1023: max CLK cycles to wait on any single handshake phase before aborting.
- CSR_CH_EN, 4'b0001: channel-enable nibble written to CSR[7:4]. CSR[3:0] is always 4'b0000: 2-wire serial, MSB-first.

- CLK  in  1  system clock.
- RESET_N  in  1  reset; asynchronous, active-low.
- START  in  1  one-cycle request; sampled only in IDLE.
- WR_EN  in  4  per-register write enables: [0] CSR, [1] CTW0, [2] CPOW0, [3] ACR.
- FTW  in  32  frequency tuning word, to CTW0.
- POW  in  14  phase offset word, to CPOW0.
- ASF  in  10  amplitude scale factor, to ACR.
- OVER  in  1  writer status; high = idle / chip deselected.
- TR  out  1  write request to writer.
- REG_ADDR  out  8  register address to writer.
- DATA_IN  out  32  right-aligned register data to writer.
- BUSY  out  1  high from the cycle after START acceptance until DONE/ERR.
- DONE  out  1  one-cycle pulse: all enabled writes finished.
- ERR  out  1  one-cycle pulse: timeout abort.

## Operation
- Write order is fixed: CSR (0x00), CTW0 (0x04), CPOW0 (0x05), ACR (0x06). A write whose WR_EN bit is 0 is skipped.
- Data words for each register:
  - CSR: {24'b0, CSR_CH_EN, 4'b0000}
  - CTW0: FTW
  - CPOW0: {18'b0, POW}
  - ACR: {19'b0, 1'b1, 2'b0, ASF} (bit 12 enables the amplitude multiplier)
- On START acceptance, FTW, POW, ASF and WR_EN are latched. Later input changes have no effect until the next START.
- States:
  - IDLE: BUSY=0. START=1 → SEL.
  - SEL: find the next enabled index at or above the pointer. None left → FIN. Otherwise load REG_ADDR/DATA_IN, clear timer → REQ.
  - REQ: TR=1. OVER=0 → clear timer → WAIT. Timer reaching TIMEOUT_CYC → ABORT.
  - WAIT: TR=0. OVER=1 → increment pointer → SEL. Timer reaching TIMEOUT_CYC → ABORT.
  - FIN: DONE=1 → IDLE.
  - ABORT: ERR=1 → IDLE.
- WR_EN=0000 → SEL goes straight to FIN; DONE is pulsed with no TR activity.
- START asserted while BUSY is ignored (not queued).
- REG_ADDR/DATA_IN are held stable from SEL until the pointer increments.
- Pointer is 3 bits; wrap past index 3 is impossible because SEL exits to FIN.
- Timer is $clog2(TIMEOUT_CYC+1) bits and saturates; it never wraps.

## Timing
- Reset values: TR=0, REG_ADDR=0, DATA_IN=0, BUSY=0, DONE=0, ERR=0; state IDLE; pointer 0; timer 0.
- START in cycle n → BUSY=1 and state SEL in n+1 → TR=1 in n+2.
- TR stays high until OVER is sampled low. It drops in the cycle after that sample, so the writer sees exactly one request per register.
- After OVER returns high: next TR rises 2 cycles later (WAIT→SEL→REQ).
- DONE/ERR: one cycle, registered, coincident with the last BUSY=1 cycle. BUSY=0 the following cycle.
- Async reset during any state: all outputs return to reset values immediately. The partially written register is not resumed.
- OVER low in IDLE or SEL is ignored.

## Structure
- Package ad9911_pkg holds:
  - register address constants (CSR=8'h00, CTW0=8'h04, CPOW0=8'h05, ACR=8'h06)
  - state enum
  - ACR multiplier-enable bit index (12)
- Sub-module ad9911_hs_timer: loadable saturating counter with a timeout flag, shared by REQ and WAIT.
- Everything else is a single FSM.

## Test plan
- WR_EN=1111, FTW=32'h1999_999A, POW=14'h0800, ASF=10'h3FF, writer model → four TRs with (REG_ADDR, DATA_IN) = (00, 00000010), (04, 1999999A), (05, 00000800), (06, 000013FF), then one DONE pulse.
- WR_EN=0010 → exactly one transfer (04, FTW); WR_EN=0000 → DONE 2 cycles after START, TR never high.
- OVER stuck high with TIMEOUT_CYC=15 → TR high for 16 cycles, then ERR pulse, BUSY low, TR low.
- START re-pulsed mid-sequence, and FTW changed mid-sequence → ignored; sent data matches the values latched at the first START.
- RESET_N low while in WAIT for CTW0 → TR/BUSY/REG_ADDR/DATA_IN go to 0 asynchronously. A new START after release restarts at CSR.
- Writer model holding OVER low for 300 cycles with TIMEOUT_CYC=1023 → no ERR; sequence completes normally.
